uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised successor to the team's fixed-format 8N1 UART receiver.
- Configurable data width, parity mode, stop-bit count and oversampling ratio.
- 3-sample majority voting, per-word framing/parity error flags, ready/valid output with overrun detection, line-idle indicator.
- Sits between the board RxD pin and any byte-stream consumer (command parser, FIFO).

Parameters:
- ClkFrequency, 16000000, system clock in Hz.
- Baud, 1000000, line rate in bit/s.
- Oversampling, 16, ticks per bit; power of 2, minimum 8.
- DataBits, 8, data bits per frame; legal range 5..9.
- Parity, 0, parity mode: 0 none, 1 odd, 2 even.
- StopBits, 1, stop bits checked; 1 or 2.
- IdleBits, 10, bit times of continuous high line before rx_idle asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- RxD  in  1  asynchronous serial line, idle high.
- rx_data  out  DataBits  received word, LSB = first bit on the line.
- rx_frame_err  out  1  first stop bit sampled low for this word.
- rx_parity_err  out  1  parity mismatch for this word; always 0 when Parity=0.
- rx_valid  out  1  holding register contains a word.
- rx_ready  in  1  consumer accepts the word on the cycle where rx_valid & rx_ready.
- rx_overrun  out  1  sticky: at least one word was dropped.
- rx_idle  out  1  line high and FSM in IDLE for IdleBits bit times.
- rx_break  out  1  one-cycle pulse on break detection; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset and clocking (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except rx_idle, which is 0 until IdleBits bit times elapse. Synchroniser flops reset to 1; FSM resets to IDLE.
- Reset mid-frame aborts the frame; no word is delivered.
- Synchronisation: 2-flop synchroniser on RxD, clocked every clk.
- Tick generation: fractional phase accumulator produces a one-clk tick at Baud*Oversampling. Accumulator resets to 0 and free-runs; rate error below 2%.
- Bit sampling: all bit sampling happens on ticks. The per-bit tick counter (log2(Oversampling) bits) wraps at Oversampling. Each bit value is the majority of the samples at counts M-1, M, M+1, where M = Oversampling/2.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a synchronised 0 on a tick goes to START and clears the counter.
  - START: vote at M. If result is 1, it is a false start; return to IDLE with no flags. If 0, go to DATA.
  - DATA: DataBits votes, shifted in LSB first. Then go to PARITY if Parity != 0, else STOP.
  - PARITY: one vote; mismatch sets the pending parity error.
  - STOP: StopBits votes. A low first stop bit sets frame_err. A low second stop bit also sets frame_err.
  - After the last stop vote: commit the word. Go to IDLE if the last stop bit was high, else WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line is 1, so a stuck-low line does not retrigger.
- Commit: occurs on the clk after the last stop vote (M+1 count of the final stop bit).
  - If the holding register is empty, or is being drained in the same cycle (rx_valid & rx_ready): load data and both flags, assert rx_valid.
  - Otherwise drop the new word and set rx_overrun.
- rx_valid clears on handshake unless a commit happens in the same cycle.
- rx_overrun clears only on a handshake cycle with no simultaneous drop.
- Stability: rx_data and flags stay stable while rx_valid=1 and rx_ready=0.
- rx_idle: a counter of ticks, cleared whenever the FSM is not in IDLE or the line is low. rx_idle is set at IdleBits*Oversampling ticks and saturates.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- Defined: a frame whose start, all data, parity and first stop samples are all 0 is not committed. rx_break pulses for one clk at the point commit would occur; the FSM enters WAIT_HIGH. rx_valid and rx_overrun are unaffected.
- Undefined: the same frame is committed as data 0 with rx_frame_err=1; rx_break is tied 0.

Decomposition:
- Package uart_pkg:
  - parity enum PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state enum;
  - function clog2;
  - localparam helpers for accumulator width and increment.
- Sub-module uart_tick_gen: phase-accumulator tick generator with async active-high reset.
- Majority vote and FSM stay in the top module.

Test Plan:
- Defaults (1 tick/clk), send 0xA5 8N1, rx_ready=1 → rx_valid for 1 clk, rx_data=0xA5, both error flags 0.
- Parity=2, DataBits=7: send 0x35 with correct parity bit 0 → parity_err=0. Same frame with parity bit 1 → parity_err=1, data 0x35.
- rx_ready=0, send 0x11 then 0x22 → rx_data holds 0x11 and rx_overrun=1. Raise rx_ready → handshake, then rx_overrun=0.
- Glitch: 3-tick low pulse on idle line → no START commit, rx_valid stays 0. Single-tick inversion at sample M of a data bit → correct value via majority.
- Stop bit low on 0x7E → rx_frame_err=1. Line held low 40 bit times: with UART_RX_BREAK_EN, one rx_break pulse and no rx_valid; without, one word 0x00 with frame_err=1 and no further words until the line rises.
- Line high after reset: rx_idle rises exactly IdleBits*Oversampling ticks later. rst asserted mid-DATA → all outputs 0 immediately and no word delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constant helpers for the parametrised UART receiver.
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

    localparam int AccWidth = 16;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Rounded phase increment so that carries occur at rate/clk_hz of the clock rate.
    function automatic longint acc_inc(input longint clk_hz, input longint rate);
        return (rate * (longint'(1) << AccWidth) + clk_hz / 2) / clk_hz;
    endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: fractional phase accumulator emitting a one-clk tick at Rate Hz.
module uart_tick_gen import uart_pkg::*; #(
    parameter int ClkFrequency = 16000000,
    parameter int Rate = 16000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam longint IncL = acc_inc(longint'(ClkFrequency), longint'(Rate));
    localparam logic [AccWidth:0] Inc = IncL[AccWidth:0];

    logic [AccWidth-1:0] acc;
    logic [AccWidth:0] sum;

    assign sum = {1'b0, acc} + Inc;
    assign tick = sum[AccWidth];

    always_ff @(posedge clk or posedge rst)
        if (rst) acc <= '0;
        else acc <= sum[AccWidth-1:0];
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample voting, ready/valid output, overrun and idle status.
// Define UART_RX_BREAK_EN to report all-zero frames as a one-clk rx_break pulse instead of committing them.
module uart_rx_param import uart_pkg::*; #(
    parameter int ClkFrequency = 16000000,
    parameter int Baud = 1000000,
    parameter int Oversampling = 16,
    parameter int DataBits = 8,
    parameter int Parity = 0,
    parameter int StopBits = 1,
    parameter int IdleBits = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic RxD,
    output logic [DataBits-1:0] rx_data,
    output logic rx_frame_err,
    output logic rx_parity_err,
    output logic rx_valid,
    input  logic rx_ready,
    output logic rx_overrun,
    output logic rx_idle,
    output logic rx_break
);
    localparam int M = Oversampling / 2;
    localparam int CW = clog2(Oversampling);
    localparam int BW = clog2(DataBits + 1);
    localparam int IdleTicks = IdleBits * Oversampling;
    localparam int IW = clog2(IdleTicks + 1);

    state_e state, state_n;
    logic s1, s2, tick, vote, at_vote, last_data, last_stop, end_frame, brk_frame, commit, accept;
    logic [1:0] samp;
    logic [CW-1:0] cnt;
    logic [BW-1:0] nbit;
    logic [DataBits-1:0] sh;
    logic par_err_p, ferr_p;
    logic [IW-1:0] idle_cnt;

    uart_tick_gen #(.ClkFrequency(ClkFrequency), .Rate(Baud * Oversampling)) u_tick (
        .clk(clk),
        .rst(rst),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) {s1, s2} <= 2'b11;
        else {s1, s2} <= {RxD, s1};

    // Samples at M-1 and M are held; the vote completes with the live sample at M+1.
    assign vote = (samp[0] & samp[1]) | (samp[0] & s2) | (samp[1] & s2);
    assign at_vote = tick && cnt == CW'(M + 1);
    assign last_data = nbit == BW'(DataBits - 1);
    assign last_stop = nbit == BW'(StopBits - 1);
    assign end_frame = at_vote && state == STOP && last_stop;
    assign commit = end_frame && !brk_frame;
    assign accept = !rx_valid || rx_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = tick && !s2 ? START : IDLE;
            START: if (at_vote) state_n = vote ? IDLE : DATA;
            DATA: if (at_vote && last_data) state_n = Parity != int'(PAR_NONE) ? PARITY : STOP;
            PARITY: if (at_vote) state_n = STOP;
            STOP: if (end_frame) state_n = vote && !brk_frame ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (s2) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            samp <= 2'b11;
            nbit <= '0;
            sh <= '0;
            par_err_p <= 1'b0;
            ferr_p <= 1'b0;
        end else begin
            cnt <= state == IDLE ? '0 : cnt + CW'(tick);
            if (tick && cnt == CW'(M - 1)) samp[0] <= s2;
            if (tick && cnt == CW'(M)) samp[1] <= s2;
            nbit <= state != state_n ? '0 : nbit + BW'(at_vote);
            if (state == IDLE) {par_err_p, ferr_p} <= 2'b00;
            if (at_vote && state == DATA) sh <= {vote, sh[DataBits-1:1]};
            if (at_vote && state == PARITY) par_err_p <= (^sh ^ vote) != (Parity == int'(PAR_ODD));
            if (at_vote && state == STOP) ferr_p <= ferr_p | !vote;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rx_data <= '0;
            rx_frame_err <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_valid <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (commit && accept) begin
                rx_data <= sh;
                rx_frame_err <= ferr_p | !vote;
                rx_parity_err <= par_err_p;
            end
            rx_valid <= (commit && accept) || (rx_valid && !rx_ready);
            rx_overrun <= (commit && !accept) || (rx_overrun && !(rx_valid && rx_ready));
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) idle_cnt <= '0;
        else if (state != IDLE || !s2) idle_cnt <= '0;
        else if (tick && !rx_idle) idle_cnt <= idle_cnt + 1'b1;

    assign rx_idle = idle_cnt == IW'(IdleTicks);

`ifdef UART_RX_BREAK_EN
    // Tracks whether every vote from start through the first stop bit was 0.
    logic zeros;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            zeros <= 1'b1;
            rx_break <= 1'b0;
        end else begin
            rx_break <= end_frame && brk_frame;
            if (state == IDLE) zeros <= 1'b1;
            else if (at_vote && (state != STOP || nbit == '0)) zeros <= zeros & !vote;
        end
    assign brk_frame = zeros && (StopBits == 2 || !vote);
`else
    assign brk_frame = 1'b0;
    assign rx_break = 1'b0;
`endif
endmodule
